// File: rtl/memarb_pkg.sv
// Shared types and helpers for the fetch/data memory port arbiter.
// The optional fetch-fairness counter is enabled by defining MEMARB_FAIRNESS_EN.
package memarb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  // An access is misaligned if it does not fit its natural boundary,
  // or if the width code is the reserved one.
  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] lo);
    logic mis;
    case (width)
      W_BYTE:  mis = 1'b0;
      W_HALF:  mis = lo[0];
      W_WORD:  mis = |lo;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// Combinational byte-lane steering: byte enables, store-data replication,
// load-data lane extraction with sign/zero extension, and misalign detect.
module mem_lane_steer
  import memarb_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  addr_lo,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [31:0] shifted;

  assign shifted  = rdata >> {addr_lo, 3'b000};
  assign misalign = misaligned(width, addr_lo);

  // Select enables, replicate store data and extend the addressed load lane.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = rdata;
    case (width)
      W_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      W_HALF: begin
        be        = 4'b0011 << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sext & shifted[15]}}, shifted[15:0]};
      end
      W_WORD: begin
        be = 4'b1111;
      end
      default: begin
        be        = 4'b0000;
        rdata_ext = '0;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one variable-latency
// memory port with a req/ack handshake. Data has priority; when
// MEMARB_FAIRNESS_EN is defined, fetch is forced through after STARVE_LIMIT
// consecutive data grants taken while fetch was waiting.
module mem_port_arbiter
  import memarb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [1:0]        d_width_i,
  input  logic              d_sext_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              d_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o
);

  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t      state_reg, state_next;
  owner_t      owner_reg;
  logic [1:0]  width_reg;
  logic [1:0]  lo_reg;
  logic        sext_reg;

  logic        is_idle;
  logic        grant_d, grant_if, fetch_turn;
  logic [1:0]  st_width, st_lo;
  logic        st_sext, st_misalign;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, st_rdata;

  assign is_idle = (state_reg == IDLE);

  // While idle the steering looks at the live request; afterwards it uses
  // the fields captured at grant so the load result never depends on inputs.
  assign st_width = is_idle ? d_width_i     : width_reg;
  assign st_lo    = is_idle ? d_addr_i[1:0] : lo_reg;
  assign st_sext  = is_idle ? d_sext_i      : sext_reg;

  mem_lane_steer u_steer (
    .width     (st_width),
    .addr_lo   (st_lo),
    .sext      (st_sext),
    .wdata     (d_wdata_i),
    .rdata     (mem_rdata_i),
    .be        (st_be),
    .wdata_rep (st_wdata),
    .rdata_ext (st_rdata),
    .misalign  (st_misalign)
  );

`ifdef MEMARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt_reg;

  assign fetch_turn = (int'(starve_cnt_reg) >= STARVE_LIMIT);

  // Count data grants that overtook a waiting fetch; any fetch grant clears.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_cnt_reg <= '0;
    end else if (grant_if) begin
      starve_cnt_reg <= '0;
    end else if (grant_d && if_req_i && !fetch_turn) begin
      starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end
`else
  assign fetch_turn = 1'b0;
`endif

  assign grant_d  = is_idle & d_req_i & ~(fetch_turn & if_req_i);
  assign grant_if = is_idle & if_req_i & ~grant_d;

  assign stall_o = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o);

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; misaligned data skips the memory and answers at once.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_d)       state_next = st_misalign ? RESP : BUSY;
        else if (grant_if) state_next = BUSY;
      end
      BUSY:    if (mem_ack_i) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory-side request registers and requester responses.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner_reg   <= OWN_IF;
      width_reg   <= '0;
      lo_reg      <= '0;
      sext_reg    <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
      if_ack_o    <= 1'b0;
      if_rdata_o  <= '0;
      d_ack_o     <= 1'b0;
      d_err_o     <= 1'b0;
      d_rdata_o   <= '0;
    end else begin
      if_ack_o <= 1'b0;
      d_ack_o  <= 1'b0;
      d_err_o  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_d) begin
            owner_reg <= OWN_D;
            width_reg <= d_width_i;
            lo_reg    <= d_addr_i[1:0];
            sext_reg  <= d_sext_i;
            if (st_misalign) begin
              d_ack_o   <= 1'b1;
              d_err_o   <= 1'b1;
              d_rdata_o <= '0;
            end else begin
              mem_req_o   <= 1'b1;
              mem_we_o    <= d_we_i;
              mem_addr_o  <= d_addr_i & WORD_MASK;
              mem_be_o    <= st_be;
              mem_wdata_o <= st_wdata;
            end
          end else if (grant_if) begin
            owner_reg   <= OWN_IF;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= if_addr_i & WORD_MASK;
            mem_be_o    <= 4'b1111;
            mem_wdata_o <= '0;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            if (owner_reg == OWN_D) begin
              d_ack_o   <= 1'b1;
              d_rdata_o <= st_rdata;
            end else begin
              if_ack_o   <= 1'b1;
              if_rdata_o <= mem_rdata_i;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter. A byte-array
// reference memory predicts every load, fetch, enable and lane pattern.
module tb_mem_port_arbiter;

  logic        clk_i, rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        if_ack_o;
  logic        d_req_i, d_we_i, d_sext_i;
  logic [1:0]  d_width_i;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic        d_ack_o, d_err_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic        stall_o;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 1;

  logic [7:0] mem_b [256];  // memory behind the port
  logic [7:0] ref_b [256];  // independent prediction of memory contents

  mem_port_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_width_i(d_width_i), .d_sext_i(d_sext_i),
    .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o),
    .d_ack_o(d_ack_o), .d_err_o(d_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_o(stall_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory: acks mem_lat cycles after first seeing a request, applies writes.
  initial begin : responder
    bit         busy = 1'b0;
    int         cnt  = 0;
    logic [7:0] base;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      if (!rst_i) begin
        mem_ack_i = 1'b0; busy = 1'b0;
      end else if (mem_ack_i) begin
        mem_ack_i = 1'b0; busy = 1'b0;
      end else if (mem_req_o) begin
        if (!busy) begin busy = 1'b1; cnt = mem_lat; end
        if (cnt == 0) begin
          base = mem_addr_o[7:0];
          mem_rdata_i = {mem_b[base+8'd3], mem_b[base+8'd2], mem_b[base+8'd1], mem_b[base]};
          if (mem_we_o)
            for (int i = 0; i < 4; i++)
              if (mem_be_o[i]) mem_b[base+8'(i)] = mem_wdata_o[8*i +: 8];
          mem_ack_i = 1'b1;
        end else begin
          cnt--;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  function automatic int nbytes(input logic [1:0] width);
    return (width == 2'd3) ? 0 : (1 << width);
  endfunction

  function automatic bit is_mis(input logic [1:0] width, input logic [31:0] addr);
    int n = nbytes(width);
    if (n == 0) return 1'b1;
    return (addr % n) != 0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    logic [7:0] a = addr[7:0] & 8'hFC;
    return {ref_b[a+8'd3], ref_b[a+8'd2], ref_b[a+8'd1], ref_b[a]};
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] width, input logic sext);
    int n = nbytes(width);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_b[addr[7:0] + 8'(i)]) << (8*i));
    if (sext && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [1:0] width);
    int lo = int'(addr[1:0]);
    int n  = nbytes(width);
    logic [3:0] be = '0;
    for (int i = 0; i < 4; i++) be[i] = (i >= lo) && (i < lo + n);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] data, input logic [1:0] width);
    int n = nbytes(width);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = data[8*(i % n) +: 8];
    return w;
  endfunction

  task automatic set_word(input logic [31:0] addr, input logic [31:0] w);
    logic [7:0] a = addr[7:0] & 8'hFC;
    for (int i = 0; i < 4; i++) begin
      mem_b[a+8'(i)] = w[8*i +: 8];
      ref_b[a+8'(i)] = w[8*i +: 8];
    end
  endtask

  task automatic do_fetch(input logic [31:0] addr, input int lat);
    int c = 0;
    step();
    if_addr_i = addr; if_req_i = 1'b1; mem_lat = lat;
    @(negedge clk_i);
    check("if_stall_wait", 32'(stall_o), 1);
    while (!if_ack_o && c < 100) begin
      c++;
      @(negedge clk_i);
      if (c == 1) begin
        check("if_mem_req", 32'(mem_req_o), 1);
        check("if_mem_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
        check("if_mem_be", 32'(mem_be_o), 32'hF);
        check("if_mem_we", 32'(mem_we_o), 0);
      end
    end
    check("if_ack_seen", 32'(if_ack_o), 1);
    check("if_latency", c, lat + 2);
    check("if_rdata", if_rdata_o, ref_word(addr));
    check("if_stall_ack", 32'(stall_o), 0);
    $display("fetch addr=%08h lat=%0d cycles=%0d rdata=%08h", addr, lat, c, if_rdata_o);
    step();
    if_req_i = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [1:0] width, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata, input int lat);
    int c = 0;
    bit mis = is_mis(width, addr);
    bit saw_req = 1'b0;
    step();
    d_we_i = we; d_width_i = width; d_sext_i = sext; d_addr_i = addr; d_wdata_i = wdata;
    d_req_i = 1'b1; mem_lat = lat;
    @(negedge clk_i);
    check("d_stall_wait", 32'(stall_o), 1);
    if (mem_req_o) saw_req = 1'b1;
    while (!d_ack_o && c < 100) begin
      c++;
      @(negedge clk_i);
      if (mem_req_o) saw_req = 1'b1;
      if (c == 1 && !mis) begin
        check("d_mem_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
        check("d_mem_be", 32'(mem_be_o), 32'(model_be(addr, width)));
        check("d_mem_we", 32'(mem_we_o), 32'(we));
        if (we) check("d_mem_wdata", mem_wdata_o, model_wdata(wdata, width));
      end
    end
    check("d_ack_seen", 32'(d_ack_o), 1);
    check("d_latency", c, mis ? 1 : lat + 2);
    check("d_err", 32'(d_err_o), 32'(mis));
    check("d_mem_access", 32'(saw_req), 32'(!mis));
    if (mis)       check("d_rdata_err", d_rdata_o, 0);
    else if (!we)  check("d_rdata", d_rdata_o, model_load(addr, width, sext));
    check("d_stall_ack", 32'(stall_o), 0);
    if (!mis && we)
      for (int i = 0; i < nbytes(width); i++) ref_b[addr[7:0] + 8'(i)] = wdata[8*i +: 8];
    $display("data we=%0b w=%0d sext=%0b addr=%08h wdata=%08h lat=%0d cycles=%0d err=%0b rdata=%08h",
             we, width, sext, addr, wdata, lat, c, d_err_o, d_rdata_o);
    step();
    d_req_i = 1'b0;
  endtask

  initial begin : main
    logic [31:0] v;
    int dg;
    bit fetch_seen, prev_req;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      mem_b[i] = v[7:0];
      ref_b[i] = v[7:0];
    end
    rst_i = 1'b0; if_req_i = 1'b0; if_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_width_i = 2'b10; d_sext_i = 1'b0;
    d_addr_i = '0; d_wdata_i = '0;

    // Reset state.
    repeat (3) @(negedge clk_i);
    check("rst_mem_req", 32'(mem_req_o), 0);
    check("rst_if_ack", 32'(if_ack_o), 0);
    check("rst_d_ack", 32'(d_ack_o), 0);
    check("rst_d_err", 32'(d_err_o), 0);
    check("rst_if_rdata", if_rdata_o, 0);
    check("rst_d_rdata", d_rdata_o, 0);
    check("rst_stall", 32'(stall_o), 0);
    $display("reset released");
    step();
    rst_i = 1'b1;

    // Fetch only, memory answers one cycle after the request appears.
    do_fetch(32'h0000_0100, 1);

    // Simultaneous requests: data first, fetch after data's response.
    set_word(32'h10, 32'h1122_3344);
    set_word(32'h20, 32'h5566_7788);
    step();
    mem_lat = 1;
    d_we_i = 1'b0; d_width_i = 2'b10; d_sext_i = 1'b0; d_addr_i = 32'h10; d_req_i = 1'b1;
    if_addr_i = 32'h20; if_req_i = 1'b1;
    @(negedge clk_i); check("both_stall", 32'(stall_o), 1);
    step(); @(negedge clk_i);
    check("both_req_c1", 32'(mem_req_o), 1);
    check("both_addr_c1", mem_addr_o, 32'h10);
    step(); step(); @(negedge clk_i);
    check("both_d_ack_c3", 32'(d_ack_o), 1);
    check("both_if_ack_c3", 32'(if_ack_o), 0);
    check("both_noissue_resp", 32'(mem_req_o), 0);
    check("both_d_rdata", d_rdata_o, ref_word(32'h10));
    step(); d_req_i = 1'b0; @(negedge clk_i);
    check("both_idle_c4", 32'(mem_req_o), 0);
    step(); @(negedge clk_i);
    check("both_req_c5", 32'(mem_req_o), 1);
    check("both_addr_c5", mem_addr_o, 32'h20);
    step(); step(); @(negedge clk_i);
    check("both_if_ack_c7", 32'(if_ack_o), 1);
    check("both_if_rdata", if_rdata_o, ref_word(32'h20));
    $display("simultaneous: data then fetch done");
    step(); if_req_i = 1'b0;

    // Byte store at 0x203, half loads with and without sign extension.
    do_data(1'b1, 2'b00, 1'b0, 32'h0000_0203, 32'h0000_00AB, 1);
    set_word(32'h200, 32'h8001_0000);
    do_data(1'b0, 2'b01, 1'b1, 32'h0000_0202, 32'h0, 1);
    check("half_sext_value", d_rdata_o, 32'hFFFF_8001);
    do_data(1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'h0, 2);
    check("half_zext_value", d_rdata_o, 32'h0000_8001);

    // Misaligned accesses answer without touching memory.
    do_data(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 1);
    do_data(1'b1, 2'b11, 1'b0, 32'h0000_0100, 32'h1234_5678, 1);

    // Random single-requester traffic against the reference memory.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a, wd;
      logic [1:0]  w;
      logic        sx;
      int          kind, lat;
      kind = int'($urandom_range(0, 2));
      lat  = int'($urandom_range(0, 3));
      a    = $urandom & 32'h0000_0FFF;
      wd   = $urandom;
      w    = 2'($urandom_range(0, 3));
      sx   = 1'($urandom_range(0, 1));
      if (kind == 0) do_fetch(a & 32'hFFFF_FFFC, lat);
      else           do_data(kind == 2, w, sx, a, wd, lat);
    end

    // Asynchronous reset while memory is stalled mid-transaction.
    step();
    mem_lat = 30;
    d_we_i = 1'b0; d_width_i = 2'b10; d_addr_i = 32'h40; d_req_i = 1'b1;
    step(); step();
    @(negedge clk_i);
    check("busy_before_rst", 32'(mem_req_o), 1);
    #2;
    d_req_i = 1'b0;
    rst_i = 1'b0;
    #1;
    check("arst_mem_req", 32'(mem_req_o), 0);
    check("arst_mem_addr", mem_addr_o, 0);
    check("arst_mem_be", 32'(mem_be_o), 0);
    check("arst_mem_wdata", mem_wdata_o, 0);
    check("arst_if_rdata", if_rdata_o, 0);
    check("arst_d_rdata", d_rdata_o, 0);
    check("arst_acks", {30'd0, if_ack_o, d_ack_o}, 0);
    check("arst_stall", 32'(stall_o), 0);
    $display("async reset during busy applied");
    step(); step();
    rst_i = 1'b1;
    do_fetch(32'h0000_0044, 0);

`ifdef MEMARB_FAIRNESS_EN
    // Continuous data requests must let fetch through after four grants.
    step();
    mem_lat = 0;
    d_we_i = 1'b0; d_width_i = 2'b10; d_addr_i = 32'h04; d_req_i = 1'b1;
    if_addr_i = 32'h80; if_req_i = 1'b1;
    dg = 0; fetch_seen = 1'b0; prev_req = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk_i);
      if (mem_req_o && !prev_req) begin
        if (mem_addr_o == 32'h80) fetch_seen = 1'b1;
        else if (!fetch_seen)     dg++;
      end
      prev_req = mem_req_o;
      if (if_ack_o) break;
    end
    check("fair_fetch_granted", 32'(fetch_seen), 1);
    check("fair_data_grants", dg, 4);
    $display("fairness: %0d data grants before fetch", dg);
    step();
    if_req_i = 1'b0; d_req_i = 1'b0;
`else
    dg = 0; fetch_seen = 1'b0; prev_req = 1'b0;
`endif

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port, variable-latency unified memory between the instruction-fetch stage and the data-memory stage of the 5-stage RISC-V pipeline. It arbitrates the two requesters and runs a req/ack transaction to memory. It handles byte/half/word lane steering, sign extension and misalignment detection. It also drives a pipeline-wide stall while any requester is waiting.

Parameters:
ADDR_W, 32, address width of requesters and memory port
DATA_W, 32, data width; fixed at 32 (4 byte lanes)
STARVE_LIMIT, 4, consecutive data grants tolerated while fetch waits (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
if_req_i  in  1  fetch request (level)
if_addr_i  in  ADDR_W  fetch address (word aligned)
if_rdata_o  out  32  fetched instruction
if_ack_o  out  1  fetch complete (1-cycle pulse)
d_req_i  in  1  data request (level)
d_we_i  in  1  1=store, 0=load
d_width_i  in  2  00 byte, 01 half, 10 word, 11 illegal
d_sext_i  in  1  sign-extend load result
d_addr_i  in  ADDR_W  byte address
d_wdata_i  in  32  store data, LSB-aligned
d_rdata_o  out  32  load result, extended
d_ack_o  out  1  data complete (1-cycle pulse)
d_err_o  out  1  misaligned/illegal access; valid with d_ack_o
mem_req_o  out  1  memory request, held until mem_ack_i
mem_we_o  out  1  memory write
mem_addr_o  out  ADDR_W  word address (addr[1:0] forced 0)
mem_be_o  out  4  byte enables
mem_wdata_o  out  32  lane-replicated write data
mem_rdata_i  in  32  memory read word; valid with mem_ack_i
mem_ack_i  in  1  memory completion
stall_o  out  1  pipeline stall

Behaviour:
- Requester contract: hold req and all fields stable until its ack; drop or re-request on the cycle after ack.
- FSM states:
  - IDLE: arbitrate, then load the memory-side registers.
  - BUSY: mem_req_o=1, fields frozen until mem_ack_i.
  - RESP: 1 cycle; owner's ack_o=1, rdata registered; all requests ignored; then to IDLE.
- IDLE arbitration: d_req_i beats if_req_i (older instruction). With neither asserted, stay in IDLE.
- Misaligned access goes IDLE→RESP directly with d_err_o=1, d_rdata_o=0 and no memory access. Misaligned means half with addr[0]=1, word with addr[1:0]≠0, or width=11.
- Latency: request at cycle 0 → mem_req_o at cycle 1. mem_ack_i at cycle k≥1 → ack_o at k+1. Minimum 3 cycles from request to next possible grant.
- Byte enables:
  - byte: 0001<<addr[1:0]
  - half: 0011<<addr[1:0]
  - word: 1111
- Write data: byte is replicated ×4; half is replicated ×2. Fetch always uses be=1111, we=0.
- Load data: selected lane shifted down, then sign- or zero-extended per d_sext_i (word ignores it).
- stall_o = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o). Combinational; 0 when no requests.
- mem_ack_i outside BUSY is ignored.
- Reset (async, any state):
  - FSM returns to IDLE.
  - All registered outputs go to 0, including mem_req_o, acks, d_err_o and rdata.
  - Any in-flight memory transaction is abandoned; memory must be reset alongside.

Optional Feature:
MEMARB_FAIRNESS_EN
- Defined: a saturating counter increments on each data grant issued while if_req_i is high. When the counter reaches STARVE_LIMIT, the next IDLE arbitration grants fetch even if d_req_i is high. The counter clears on any fetch grant and on reset.
- Undefined: strict data priority; the counter is absent.

Decomposition:
- Package memarb_pkg: state enum (IDLE/BUSY/RESP), width codes (W_BYTE/W_HALF/W_WORD), owner enum (OWN_IF/OWN_D), misalign function.
- Sub-module mem_lane_steer (combinational):
  - inputs: width, addr[1:0], sext, wdata, rdata
  - outputs: be, lane-replicated wdata, extended rdata, misalign flag
- The arbiter FSM instantiates it once.

Test Plan:
- Fetch only, addr 0x100, memory acks 1 cycle after req → mem_addr_o=0x100, be=1111; if_ack_o 3 cycles after request; if_rdata_o=mem word; stall_o high until ack.
- d_req_i and if_req_i in the same cycle → data granted first, fetch granted the cycle after data RESP; no double issue during RESP.
- Store byte 0xAB at addr 0x203 → mem_be_o=1000, mem_wdata_o=0xABABABAB, mem_addr_o=0x200.
- Load half at 0x202, sext=1, memory returns 0x8001_0000 → d_rdata_o=0xFFFF8001. Same with sext=0 → 0x00008001.
- Word load at 0x101 → no mem_req_o; d_ack_o and d_err_o=1 on the 2nd cycle; d_rdata_o=0.
- rst_i low during BUSY with memory stalled → all outputs 0 immediately. With MEMARB_FAIRNESS_EN and continuous d_req_i plus if_req_i, fetch is granted after 4 data grants.
